// File: rtl/sample_pkg.sv
// Shared definitions for the sample recorder: slot sizing, FSM state encoding,
// offset-binary midpoint and default geometry.
package sample_pkg;

    localparam int SLOT_W     = 2;
    localparam int NUM_SLOTS  = 1 << SLOT_W;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_THRESH = 16;

    localparam logic [7:0] MIDPOINT = 8'h80;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ARM    = 2'd1;
    localparam state_t ST_RECORD = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/rec_trigger.sv
// Level trigger: hit when an offset-binary sample lies strictly outside
// MIDPOINT +/- THRESH. Only used in builds with REC_TRIGGER_EN defined.
module rec_trigger
    import sample_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int THRESH = DEF_THRESH
) (
    input  logic [DATA_W-1:0] audio_in,
    output logic              hit
);

    // Signed int compare so MIDPOINT - THRESH may go negative without wrapping.
    assign hit = (int'(audio_in) > int'(MIDPOINT) + THRESH) ||
                 (int'(audio_in) < int'(MIDPOINT) - THRESH);

endmodule

// File: rtl/sample_recorder.sv
// Captures sample_tick-strobed audio into one of four slot RAMs and keeps a
// per-slot recorded-length table. Define REC_TRIGGER_EN for level-triggered start.
module sample_recorder
    import sample_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef REC_TRIGGER_EN
    ,
    parameter int THRESH = DEF_THRESH
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] audio_in,
    input  logic              rec_req,
    input  logic              rec_stop,
    input  logic              abort,
    input  logic [SLOT_W-1:0] slot_sel,
    output logic              wr_en,
    output logic [SLOT_W-1:0] wr_slot,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   slot_len
);

    logic trig_hit;

`ifdef REC_TRIGGER_EN
    rec_trigger #(
        .DATA_W (DATA_W),
        .THRESH (THRESH)
    ) u_rec_trigger (
        .audio_in (audio_in),
        .hit      (trig_hit)
    );
`else
    assign trig_hit = 1'b1;
`endif

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, done_q;
    logic [ADDR_W:0]   len_q [NUM_SLOTS];
    logic              do_write, commit_len;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        slot_d     = slot_q;
        count_d    = count_q;
        full_d     = full_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        do_write   = 1'b0;
        commit_len = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rec_req) begin
                    slot_d  = slot_sel;
                    count_d = '0;
                    full_d  = 1'b0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rec_stop) begin
                    state_d = ST_FINISH;
                end else if (sample_tick && trig_hit) begin
                    do_write = 1'b1;
                    state_d  = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (sample_tick) begin
                        do_write = 1'b1;
                        // Writing the last address ends the take; the counter never wraps.
                        if (count_q[ADDR_W-1:0] == '1) begin
                            full_d  = 1'b1;
                            state_d = ST_FINISH;
                        end
                    end
                    if (rec_stop) state_d = ST_FINISH;
                end
            end
            default: begin
                commit_len = !abort;
                state_d    = ST_IDLE;
            end
        endcase

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[ADDR_W-1:0];
            wr_data_d = audio_in;
            count_d   = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            count_q   <= count_d;
            full_q    <= full_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_FINISH);
        end
    end

    // NOTE: the length table is a handful of flops, not RAM, so it takes the async reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
        end else if (commit_len) begin
            len_q[slot_q] <= count_q;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_slot  = slot_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign full     = full_q;
    assign slot_len = len_q[slot_sel];

endmodule

// File: tb/tb_sample_recorder.sv
// Directed self-checking bench for sample_recorder; follows REC_TRIGGER_EN
// when the same macro is defined for the bench build.
module tb_sample_recorder;
    import sample_pkg::*;

    localparam int ADDR_W = DEF_ADDR_W;
    localparam int DATA_W = DEF_DATA_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              resetn;
    logic              sample_tick, rec_req, rec_stop, abort;
    logic [DATA_W-1:0] audio_in;
    logic [SLOT_W-1:0] slot_sel;
    logic              wr_en, busy, done, full;
    logic [SLOT_W-1:0] wr_slot;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   slot_len;

    int checks   = 0;
    int failures = 0;

    sample_recorder dut (
        .clk         (clk),
        .resetn      (resetn),
        .sample_tick (sample_tick),
        .audio_in    (audio_in),
        .rec_req     (rec_req),
        .rec_stop    (rec_stop),
        .abort       (abort),
        .slot_sel    (slot_sel),
        .wr_en       (wr_en),
        .wr_slot     (wr_slot),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .full        (full),
        .slot_len    (slot_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [SLOT_W-1:0] slot);
        slot_sel = slot;
        rec_req  = 1'b1;
        cycle();
        rec_req  = 1'b0;
        check("start_busy", busy, 1);
    endtask

    task automatic expect_write(input string tag, input logic [SLOT_W-1:0] slot,
                                input int addr, input logic [DATA_W-1:0] data);
        check({tag, "_en"}, wr_en, 1);
        check({tag, "_slot"}, wr_slot, slot);
        check({tag, "_addr"}, wr_addr, addr);
        check({tag, "_data"}, wr_data, data);
    endtask

    task automatic expect_len(input string tag, input logic [SLOT_W-1:0] slot, input int len);
        slot_sel = slot;
        #1;
        check(tag, slot_len, len);
    endtask

    task automatic stop_and_settle();
        sample_tick = 1'b0;
        rec_stop    = 1'b1;
        cycle();
        check("stop_done", done, 1);
        rec_stop = 1'b0;
        cycle();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] trig_vals [3];
        int bad;

        resetn      = 1'b0;
        sample_tick = 1'b0;
        rec_req     = 1'b0;
        rec_stop    = 1'b0;
        abort       = 1'b0;
        audio_in    = '0;
        slot_sel    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_slot", wr_slot, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_full", full, 0);
        for (int s = 0; s < NUM_SLOTS; s++) expect_len("rst_len", SLOT_W'(s), 0);
        resetn = 1'b1;
        cycle();

        // Basic: slot 2, five samples then stop
        start(2);
        check("arm_no_write", wr_en, 0);
        for (int i = 0; i < 5; i++) begin
            sample_tick = 1'b1;
            audio_in    = DATA_W'(8'h10 + i);
            cycle();
            expect_write("basic", 2, i, DATA_W'(8'h10 + i));
        end
        stop_and_settle();
        check("basic_no_wr", wr_en, 0);
        expect_len("basic_len", 2, 5);

        // Seed slot 1 with length 5, then abort a re-record
        start(1);
        for (int i = 0; i < 5; i++) begin
            sample_tick = 1'b1;
            audio_in    = DATA_W'(8'hA0 + i);
            cycle();
        end
        stop_and_settle();
        expect_len("seed_len", 1, 5);

        start(1);
        for (int i = 0; i < 3; i++) begin
            sample_tick = 1'b1;
            audio_in    = DATA_W'(8'hC0 + i);
            cycle();
        end
        expect_write("rerec", 1, 2, 8'hC2);
        abort       = 1'b1;
        sample_tick = 1'b1;
        audio_in    = 8'hEE;
        cycle();
        check("abort_no_wr", wr_en, 0);
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);
        abort       = 1'b0;
        sample_tick = 1'b0;
        cycle();
        check("abort_no_done2", done, 0);
        expect_len("abort_len", 1, 5);

        // rec_req while busy ignored; stop coinciding with a tick still writes
        start(0);
        rec_req     = 1'b1;
        slot_sel    = 3;
        sample_tick = 1'b1;
        audio_in    = 8'h55;
        cycle();
        expect_write("busy_req", 0, 0, 8'h55);
        rec_req  = 1'b0;
        audio_in = 8'h66;
        rec_stop = 1'b1;
        cycle();
        expect_write("stop_tick", 0, 1, 8'h66);
        check("stop_tick_done", done, 1);
        rec_stop    = 1'b0;
        sample_tick = 1'b0;
        cycle();
        check("stop_tick_idle", busy, 0);
        expect_len("stop_tick_len", 0, 2);

        // Stop while armed: zero-length take
        start(2);
        rec_stop = 1'b1;
        cycle();
        check("arm_stop_done", done, 1);
        check("arm_stop_no_wr", wr_en, 0);
        rec_stop = 1'b0;
        cycle();
        expect_len("arm_stop_len", 2, 0);

        // Start condition: quiet samples skipped only in the trigger build
        trig_vals[0] = 8'h80;
        trig_vals[1] = 8'h88;
        trig_vals[2] = 8'h91;
        start(3);
        for (int i = 0; i < 3; i++) begin
            sample_tick = 1'b1;
            audio_in    = trig_vals[i];
            cycle();
`ifdef REC_TRIGGER_EN
            if (i < 2) check("trig_quiet", wr_en, 0);
            else       expect_write("trig_hit", 3, 0, 8'h91);
`else
            expect_write("notrig", 3, i, trig_vals[i]);
`endif
        end
        stop_and_settle();
`ifdef REC_TRIGGER_EN
        expect_len("trig_len", 3, 1);
`else
        expect_len("trig_len", 3, 3);
`endif

        // Fill slot 0 with a continuous tick stream
        start(0);
        bad = 0;
        sample_tick = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            audio_in = DATA_W'(i) ^ 8'hF0;
            cycle();
            if (wr_en !== 1'b1 || wr_addr !== i[ADDR_W-1:0] || wr_data !== (DATA_W'(i) ^ 8'hF0))
                bad++;
            if (i < DEPTH - 1 && (done !== 1'b0 || full !== 1'b0)) bad++;
        end
        check("full_seq_errors", bad, 0);
        check("full_last_addr", wr_addr, DEPTH - 1);
        check("full_flag", full, 1);
        check("full_done", done, 1);
        cycle();
        check("full_no_wr", wr_en, 0);
        check("full_done_clr", done, 0);
        check("full_idle", busy, 0);
        check("full_sticky", full, 1);
        cycle();
        check("full_no_wr2", wr_en, 0);
        expect_len("full_len", 0, DEPTH);
        sample_tick = 1'b0;
        start(1);
        check("full_cleared", full, 0);

        // Async reset in the middle of a take
        sample_tick = 1'b1;
        audio_in    = 8'hF3;
        cycle();
        cycle();
        check("pre_rst_wr", wr_en, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_wr_slot", wr_slot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_full", full, 0);
        for (int s = 0; s < NUM_SLOTS; s++) expect_len("mid_rst_len", SLOT_W'(s), 0);
        sample_tick = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();
        check("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
